lrsc_event_tracker: RTL and testbench

LRSC_EVENT_TRACKER -- requirements
Module: lrsc_event_tracker

---
 rtl/lrsc_event_tracker.sv | 149 ++++++++++++++
 tb/tb_lrsc_event_tracker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lrsc_event_tracker.sv
// lrsc_event_tracker
//   Tracks a single load-reserved / store-conditional reservation for one
//   hart. It reports each SC outcome to the core and to difftest one cycle
//   after the SC commits, and keeps a saturating count of failed SCs.
//
//   A reservation covers one granule (2**GRANULE_BITS bytes). It is dropped by:
//   any SC, a flush, a probe/eviction to the reserved granule, or expiry of
//   the life counter.
//
// Ports
//   clock, reset             sole clock, synchronous active-high reset
//   io_hartid                core id, captured with each SC
//   io_lr_valid/io_lr_addr   LR commit and its physical address
//   io_sc_valid/io_sc_addr   SC commit and its physical address
//   io_probe_valid/_addr     coherence probe or eviction hitting the L1
//   io_flush                 pipeline redirect/exception, kills reservation
//   io_sc_resp_valid/_success  SC result to the core (cycle after the SC)
//   io_diff_enable/_valid/_success/_coreid  difftest SC event
//   io_sc_fail_cnt           saturating failed-SC counter
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no reservation held; any SC fails
// RESERVED | res_addr holds a live reservation, life counter is running

module lrsc_event_tracker #(
    parameter int PADDR_WIDTH  = 36,
    parameter int GRANULE_BITS = 6,
    parameter int LRSC_TIMEOUT = 100
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             io_hartid,
    input  logic                   io_lr_valid,
    input  logic [PADDR_WIDTH-1:0] io_lr_addr,
    input  logic                   io_sc_valid,
    input  logic [PADDR_WIDTH-1:0] io_sc_addr,
    input  logic                   io_probe_valid,
    input  logic [PADDR_WIDTH-1:0] io_probe_addr,
    input  logic                   io_flush,
    output logic                   io_sc_resp_valid,
    output logic                   io_sc_resp_success,
    output logic                   io_diff_enable,
    output logic                   io_diff_valid,
    output logic                   io_diff_success,
    output logic [7:0]             io_diff_coreid,
    output logic [15:0]            io_sc_fail_cnt
);

    localparam int GW     = PADDR_WIDTH - GRANULE_BITS;
    localparam int LIFE_W = (LRSC_TIMEOUT > 2) ? $clog2(LRSC_TIMEOUT) : 1;
    localparam logic [LIFE_W-1:0] LIFE_LAST = LIFE_W'(LRSC_TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        RESERVED = 1'b1
    } state_t;

    state_t              state_q, state_nxt;
    logic [GW-1:0]       res_addr_q, res_addr_nxt;
    logic [LIFE_W-1:0]   life_q, life_nxt;

    logic [GW-1:0]       lr_gran, sc_gran, probe_gran;
    logic                reserved;
    logic                probe_hit;
    logic                sc_ok;

    logic                resp_valid_q;
    logic                resp_success_q;
    logic [7:0]          coreid_q;
    logic [15:0]         fail_cnt_q;

    // Offset-within-granule bits never take part in matching.
    logic                unused_low_bits;
    assign unused_low_bits = ^{io_lr_addr[GRANULE_BITS-1:0],
                               io_sc_addr[GRANULE_BITS-1:0],
                               io_probe_addr[GRANULE_BITS-1:0]};

    assign lr_gran    = io_lr_addr[PADDR_WIDTH-1:GRANULE_BITS];
    assign sc_gran    = io_sc_addr[PADDR_WIDTH-1:GRANULE_BITS];
    assign probe_gran = io_probe_addr[PADDR_WIDTH-1:GRANULE_BITS];

    assign reserved  = (state_q == RESERVED);
    assign probe_hit = reserved && io_probe_valid && (probe_gran == res_addr_q);

    // A same-cycle matching probe or flush wins the race against the SC.
    assign sc_ok = io_sc_valid && reserved && (sc_gran == res_addr_q)
                   && !probe_hit && !io_flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            res_addr_q <= '0;
            life_q     <= '0;
        end else begin
            state_q    <= state_nxt;
            res_addr_q <= res_addr_nxt;
            life_q     <= life_nxt;
        end
    end

    // Event priority: flush > SC > probe > LR > timeout.
    always_comb begin
        state_nxt    = state_q;
        res_addr_nxt = res_addr_q;
        life_nxt     = life_q;

        if (io_flush || io_sc_valid || probe_hit) begin
            state_nxt = IDLE;
        end else if (io_lr_valid) begin
            state_nxt    = RESERVED;
            res_addr_nxt = lr_gran;
            life_nxt     = '0;
        end else if (reserved) begin
            if (life_q == LIFE_LAST) begin
                state_nxt = IDLE;
            end else begin
                life_nxt = life_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_q   <= 1'b0;
            resp_success_q <= 1'b0;
            coreid_q       <= '0;
            fail_cnt_q     <= '0;
        end else begin
            resp_valid_q   <= io_sc_valid;
            resp_success_q <= sc_ok;
            if (io_sc_valid) begin
                coreid_q <= io_hartid;
            end
            if (io_sc_valid && !sc_ok && (fail_cnt_q != 16'hFFFF)) begin
                fail_cnt_q <= fail_cnt_q + 16'd1;
            end
        end
    end

    assign io_sc_resp_valid   = resp_valid_q;
    assign io_sc_resp_success = resp_success_q;
    assign io_diff_enable     = resp_valid_q;
    assign io_diff_valid      = resp_valid_q;
    assign io_diff_success    = resp_success_q;
    assign io_diff_coreid     = coreid_q;
    assign io_sc_fail_cnt     = fail_cnt_q;

endmodule

// File: tb/tb_lrsc_event_tracker.sv
// Directed testbench for lrsc_event_tracker.
module tb_lrsc_event_tracker;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  io_hartid;
    logic        io_lr_valid;
    logic [35:0] io_lr_addr;
    logic        io_sc_valid;
    logic [35:0] io_sc_addr;
    logic        io_probe_valid;
    logic [35:0] io_probe_addr;
    logic        io_flush;
    logic        io_sc_resp_valid;
    logic        io_sc_resp_success;
    logic        io_diff_enable;
    logic        io_diff_valid;
    logic        io_diff_success;
    logic [7:0]  io_diff_coreid;
    logic [15:0] io_sc_fail_cnt;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_fail;
    logic [7:0]  last_core;

    localparam logic [35:0] ADDR_A   = 36'h0_8000_0040;
    localparam logic [35:0] ADDR_A2  = 36'h0_8000_0078;
    localparam logic [35:0] ADDR_A3  = 36'h0_8000_0050;
    localparam logic [35:0] ADDR_B   = 36'h0_8000_0080;

    lrsc_event_tracker dut (
        .clock              (clock),
        .reset              (reset),
        .io_hartid          (io_hartid),
        .io_lr_valid        (io_lr_valid),
        .io_lr_addr         (io_lr_addr),
        .io_sc_valid        (io_sc_valid),
        .io_sc_addr         (io_sc_addr),
        .io_probe_valid     (io_probe_valid),
        .io_probe_addr      (io_probe_addr),
        .io_flush           (io_flush),
        .io_sc_resp_valid   (io_sc_resp_valid),
        .io_sc_resp_success (io_sc_resp_success),
        .io_diff_enable     (io_diff_enable),
        .io_diff_valid      (io_diff_valid),
        .io_diff_success    (io_diff_success),
        .io_diff_coreid     (io_diff_coreid),
        .io_sc_fail_cnt     (io_sc_fail_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        reset          = 1'b0;
        io_lr_valid    = 1'b0;
        io_sc_valid    = 1'b0;
        io_probe_valid = 1'b0;
        io_flush       = 1'b0;
    endtask

    // Commit the currently driven inputs on one rising edge, then sample.
    task automatic step();
        @(posedge clock);
        #1;
        clear_inputs();
    endtask

    task automatic quiet_check(input string tag);
        chk({tag, ":q_valid"},   io_sc_resp_valid,   0);
        chk({tag, ":q_success"}, io_sc_resp_success, 0);
        chk({tag, ":q_diffen"},  io_diff_enable,     0);
        chk({tag, ":q_diffval"}, io_diff_valid,      0);
        chk({tag, ":q_diffsuc"}, io_diff_success,    0);
        chk({tag, ":q_coreid"},  io_diff_coreid,     last_core);
        chk({tag, ":q_failcnt"}, io_sc_fail_cnt,     exp_fail);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_lr(input logic [35:0] a);
        io_lr_valid = 1'b1;
        io_lr_addr  = a;
        step();
    endtask

    // Caller drives io_sc_valid/io_sc_addr (and any same-cycle events) first.
    task automatic sc_check(input string tag, input logic exp_succ);
        logic [7:0] hart;
        hart = io_hartid;
        step();
        if (!exp_succ && exp_fail != 16'hFFFF) exp_fail = exp_fail + 16'd1;
        last_core = hart;
        chk({tag, ":valid"},   io_sc_resp_valid,   1);
        chk({tag, ":success"}, io_sc_resp_success, exp_succ);
        chk({tag, ":diffen"},  io_diff_enable,     1);
        chk({tag, ":diffval"}, io_diff_valid,      1);
        chk({tag, ":diffsuc"}, io_diff_success,    exp_succ);
        chk({tag, ":coreid"},  io_diff_coreid,     hart);
        chk({tag, ":failcnt"}, io_sc_fail_cnt,     exp_fail);
    endtask

    task automatic sc_to(input logic [35:0] a, input logic [7:0] hart);
        io_sc_valid = 1'b1;
        io_sc_addr  = a;
        io_hartid   = hart;
    endtask

    initial begin
        clear_inputs();
        io_hartid     = 8'h00;
        io_lr_addr    = '0;
        io_sc_addr    = '0;
        io_probe_addr = '0;
        exp_fail      = 16'd0;
        last_core     = 8'h00;

        // Reset with an SC and LR pending: no event, all outputs cleared.
        reset = 1'b1; step();
        reset = 1'b1; io_sc_valid = 1'b1; io_sc_addr = ADDR_A; io_hartid = 8'h33;
        io_lr_valid = 1'b1; io_lr_addr = ADDR_A;
        step();
        quiet_check("reset");

        // LR during reset must not have taken: first SC fails.
        sc_to(ADDR_A, 8'h11); sc_check("post_reset_sc", 1'b0);
        step(); quiet_check("post_reset_quiet");

        // LR then SC five cycles later within the same granule.
        do_lr(ADDR_A); idle(4);
        sc_to(ADDR_A2, 8'h5A); sc_check("basic", 1'b1);
        step(); quiet_check("basic_quiet");

        // Matching probe kills the reservation.
        do_lr(ADDR_A);
        io_probe_valid = 1'b1; io_probe_addr = ADDR_A3; step();
        sc_to(ADDR_A, 8'h21); sc_check("probe_hit", 1'b0);

        // Non-matching probe is ignored.
        do_lr(ADDR_A);
        io_probe_valid = 1'b1; io_probe_addr = ADDR_B; step();
        sc_to(ADDR_A, 8'h22); sc_check("probe_miss", 1'b1);

        // Timeout boundary: 100 quiet cycles expire, 99 do not.
        do_lr(ADDR_A); idle(100);
        sc_to(ADDR_A, 8'h31); sc_check("timeout_100", 1'b0);
        do_lr(ADDR_A); idle(99);
        sc_to(ADDR_A, 8'h32); sc_check("timeout_99", 1'b1);

        // SC with a same-cycle matching probe.
        do_lr(ADDR_A);
        sc_to(ADDR_A, 8'h41); io_probe_valid = 1'b1; io_probe_addr = ADDR_A;
        sc_check("sc_probe", 1'b0);

        // SC with a same-cycle flush, then a bare SC shows the FSM went idle.
        do_lr(ADDR_A);
        sc_to(ADDR_A, 8'h42); io_flush = 1'b1; sc_check("sc_flush", 1'b0);
        sc_to(ADDR_A, 8'h43); sc_check("after_flush", 1'b0);

        // Flush alone kills the reservation without an event.
        do_lr(ADDR_A);
        io_flush = 1'b1; step(); quiet_check("flush_quiet");
        sc_to(ADDR_A, 8'h44); sc_check("flush_then_sc", 1'b0);

        // SC to a different granule fails.
        do_lr(ADDR_A);
        sc_to(ADDR_B, 8'h45); sc_check("sc_addr_miss", 1'b0);

        // A second LR replaces the reservation.
        do_lr(ADDR_A); do_lr(ADDR_B);
        sc_to(ADDR_A, 8'h51); sc_check("lr_replace_old", 1'b0);
        do_lr(ADDR_A); do_lr(ADDR_B);
        sc_to(ADDR_B, 8'h52); sc_check("lr_replace_new", 1'b1);

        // LR coincident with SC is ignored; back-to-back SCs each report.
        do_lr(ADDR_A);
        sc_to(ADDR_A, 8'h61); io_lr_valid = 1'b1; io_lr_addr = ADDR_A;
        sc_check("sc_with_lr", 1'b1);
        sc_to(ADDR_A, 8'h62); sc_check("b2b_second", 1'b0);

        // Reset while reserved drops the reservation and clears state.
        do_lr(ADDR_A);
        reset = 1'b1; step();
        exp_fail = 16'd0; last_core = 8'h00;
        quiet_check("reset_reserved");
        sc_to(ADDR_A, 8'h71); sc_check("reset_then_sc", 1'b0);

        // Saturation of the failed-SC counter.
        reset = 1'b1; step();
        exp_fail = 16'd0; last_core = 8'h00;
        io_sc_valid = 1'b1; io_sc_addr = ADDR_A; io_hartid = 8'h7E;
        repeat (65534) @(posedge clock);
        #1;
        clear_inputs();
        exp_fail = 16'hFFFE;
        chk("sat_fffe", io_sc_fail_cnt, 16'hFFFE);
        sc_to(ADDR_A, 8'h7F); sc_check("sat_ffff", 1'b0);
        sc_to(ADDR_A, 8'h80); sc_check("sat_hold", 1'b0);
        step(); quiet_check("final_quiet");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
